// File: rtl/cpu_hazard_unit.sv
// cpu_hazard_unit: scoreboard-based hazard and forwarding unit.
// Tracks in-flight register writes in slots 1..DEPTH (1 = execute, DEPTH = writeback).
// For each decoded source operand it either picks a forwarding slot or stalls fetch/decode.
// Optional feature macro: HAZARD_FWD_EN.
//   Defined:   a source operand is forwarded from the youngest matching slot once that
//              slot's value is ready.
//   Undefined: no forwarding; any match in slots 1..DEPTH stalls until the writer retires.
module cpu_hazard_unit #(
    parameter int NREGS      = 8,
    parameter int RIDX_W     = $clog2(NREGS),
    parameter int DEPTH      = 3,
    parameter int LOAD_READY = 2,
    parameter int FW         = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              d_valid_i,
    input  logic [RIDX_W-1:0] d_rx_i,
    input  logic [RIDX_W-1:0] d_ry_i,
    input  logic              d_rx_used_i,
    input  logic              d_ry_used_i,
    input  logic              d_wr_en_i,
    input  logic [RIDX_W-1:0] d_wr_reg_i,
    input  logic              d_is_load_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic              issue_o,
    output logic [FW-1:0]     rx_fwd_o,
    output logic [FW-1:0]     ry_fwd_o,
    output logic [FW-1:0]     inflight_cnt_o,
    output logic [15:0]       stall_cycles_o
);

    // Scoreboard slots; index 1 is the youngest entry.
    logic [DEPTH:1]    vld_q;
    logic [DEPTH:1]    load_q;
    logic [RIDX_W-1:0] reg_q [1:DEPTH];
    logic [15:0]       stall_cycles_q;
    logic [15:0]       stall_cycles_d;

    logic [DEPTH:1] rx_match;
    logic [DEPTH:1] ry_match;
    logic           rx_haz;
    logic           ry_haz;

    // Per-slot operand match against the scoreboard.
    for (genvar gi = 1; gi <= DEPTH; gi++) begin : g_match
        assign rx_match[gi] = d_rx_used_i & vld_q[gi] & (reg_q[gi] == d_rx_i);
        assign ry_match[gi] = d_ry_used_i & vld_q[gi] & (reg_q[gi] == d_ry_i);
    end

`ifdef HAZARD_FWD_EN
    logic [DEPTH:1] slot_rdy;
    logic           rx_hit, ry_hit, rx_rdy, ry_rdy;
    logic [FW-1:0]  rx_k, ry_k;

    // A load result only becomes forwardable from slot LOAD_READY onward.
    for (genvar gi = 1; gi <= DEPTH; gi++) begin : g_rdy
        assign slot_rdy[gi] = ~load_q[gi] | ((gi >= LOAD_READY) ? 1'b1 : 1'b0);
    end

    // Youngest-match selection: scan oldest to youngest so the smallest slot wins.
    always_comb begin
        rx_hit = 1'b0;
        ry_hit = 1'b0;
        rx_rdy = 1'b1;
        ry_rdy = 1'b1;
        rx_k   = '0;
        ry_k   = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (rx_match[k]) begin
                rx_hit = 1'b1;
                rx_k   = FW'(k);
                rx_rdy = slot_rdy[k];
            end
            if (ry_match[k]) begin
                ry_hit = 1'b1;
                ry_k   = FW'(k);
                ry_rdy = slot_rdy[k];
            end
        end
        rx_haz   = rx_hit & ~rx_rdy;
        ry_haz   = ry_hit & ~ry_rdy;
        rx_fwd_o = (d_valid_i & rx_hit & rx_rdy) ? rx_k : '0;
        ry_fwd_o = (d_valid_i & ry_hit & ry_rdy) ? ry_k : '0;
    end
`else
    logic unused_load;
    assign unused_load = ^load_q;

    // Without forwarding every in-flight writer of a source is a hazard.
    always_comb begin
        rx_haz   = |rx_match;
        ry_haz   = |ry_match;
        rx_fwd_o = '0;
        ry_fwd_o = '0;
    end
`endif

    // Issue decision; a flush kills the instruction but does not mask the stall output.
    always_comb begin
        stall_o = d_valid_i & (rx_haz | ry_haz);
        issue_o = d_valid_i & ~stall_o & ~flush_i;
    end

    // Count valid in-flight writers.
    always_comb begin
        inflight_cnt_o = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            inflight_cnt_o = inflight_cnt_o + FW'(vld_q[k]);
        end
    end

    // Saturating count of cycles lost to stalls of live (unflushed) instructions.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall_o && !flush_i && stall_cycles_q != 16'hFFFF) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end
    end

    // Scoreboard shift and counter; slots advance every cycle, stalls only inject bubbles.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            vld_q          <= '0;
            load_q         <= '0;
            stall_cycles_q <= '0;
            for (int k = 1; k <= DEPTH; k++) begin
                reg_q[k] <= '0;
            end
        end else begin
            stall_cycles_q <= stall_cycles_d;
            for (int k = DEPTH; k >= 2; k--) begin
                vld_q[k]  <= vld_q[k-1];
                load_q[k] <= load_q[k-1];
                reg_q[k]  <= reg_q[k-1];
            end
            vld_q[1]  <= issue_o & d_wr_en_i;
            load_q[1] <= issue_o & d_wr_en_i & d_is_load_i;
            reg_q[1]  <= d_wr_reg_i;
        end
    end

    assign stall_cycles_o = stall_cycles_q;

endmodule

// File: tb/tb_cpu_hazard_unit.sv
// Directed-vector bench for cpu_hazard_unit with a queue-based scoreboard.
// Each vector carries hand-computed expectations for both builds (with and without
// HAZARD_FWD_EN); the column matching the current build is pushed to the queue.
module tb_cpu_hazard_unit;

    typedef struct packed {
        logic        stall;
        logic        issue;
        logic [1:0]  rxf;
        logic [1:0]  ryf;
        logic [1:0]  cnt;
        logic [15:0] sc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        d_valid = 1'b0;
    logic [2:0]  d_rx = '0, d_ry = '0, d_wr_reg = '0;
    logic        d_rx_used = 1'b0, d_ry_used = 1'b0, d_wr_en = 1'b0;
    logic        d_is_load = 1'b0, flush = 1'b0;
    logic        stall, issue;
    logic [1:0]  rx_fwd, ry_fwd, inflight_cnt;
    logic [15:0] stall_cycles;

    exp_t exp_q[$];
    int   id_q[$];
    int   checks = 0;
    int   passed = 0;
    int   vec_id = 0;

    cpu_hazard_unit dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .d_valid_i      (d_valid),
        .d_rx_i         (d_rx),
        .d_ry_i         (d_ry),
        .d_rx_used_i    (d_rx_used),
        .d_ry_used_i    (d_ry_used),
        .d_wr_en_i      (d_wr_en),
        .d_wr_reg_i     (d_wr_reg),
        .d_is_load_i    (d_is_load),
        .flush_i        (flush),
        .stall_o        (stall),
        .issue_o        (issue),
        .rx_fwd_o       (rx_fwd),
        .ry_fwd_o       (ry_fwd),
        .inflight_cnt_o (inflight_cnt),
        .stall_cycles_o (stall_cycles)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic s, input logic i, input int rf, input int yf,
                                input int c, input int sc);
        exp_t e;
        e.stall = s;
        e.issue = i;
        e.rxf   = 2'(rf);
        e.ryf   = 2'(yf);
        e.cnt   = 2'(c);
        e.sc    = 16'(sc);
        return e;
    endfunction

    // Apply one vector just after the rising edge and queue its expected response.
    task automatic step(input logic rst, input logic v, input int rx, input int ry,
                        input logic rxu, input logic ryu, input logic wr, input int wreg,
                        input logic ld, input logic fl, input exp_t e_fwd, input exp_t e_nof);
        @(posedge clk);
        #1;
        reset     = rst;
        d_valid   = v;
        d_rx      = 3'(rx);
        d_ry      = 3'(ry);
        d_rx_used = rxu;
        d_ry_used = ryu;
        d_wr_en   = wr;
        d_wr_reg  = 3'(wreg);
        d_is_load = ld;
        flush     = fl;
`ifdef HAZARD_FWD_EN
        exp_q.push_back(e_fwd);
`else
        exp_q.push_back(e_nof);
`endif
        id_q.push_back(vec_id);
        vec_id++;
    endtask

    // Monitor: outputs are combinational every cycle, so compare on the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            exp_t a;
            int   id;
            e  = exp_q.pop_front();
            id = id_q.pop_front();
            a  = {stall, issue, rx_fwd, ry_fwd, inflight_cnt, stall_cycles};
            checks++;
            if (a === e) begin
                passed++;
            end else begin
                $display("FAIL vec%0d: got stall=%0b issue=%0b rx_fwd=%0d ry_fwd=%0d cnt=%0d sc=%0d, want stall=%0b issue=%0b rx_fwd=%0d ry_fwd=%0d cnt=%0d sc=%0d",
                         id, a.stall, a.issue, a.rxf, a.ryf, a.cnt, a.sc,
                         e.stall, e.issue, e.rxf, e.ryf, e.cnt, e.sc);
            end
            $display("vec%0d stall=%0b issue=%0b rx_fwd=%0d ry_fwd=%0d cnt=%0d sc=%0d",
                     id, a.stall, a.issue, a.rxf, a.ryf, a.cnt, a.sc);
        end
    end

    initial begin
        //    rst v  rx ry rxu ryu wr wreg ld fl     expected (forwarding)    expected (no forwarding)
        // 0: reset held: empty scoreboard, issue follows d_valid
        step(1, 1, 0, 0, 0, 0, 1, 3, 0, 0, mk(0,1,0,0,0,0), mk(0,1,0,0,0,0));
        // 1..5: ALU writes r3, then readers of r3 at distances 1,2,3,4
        step(0, 1, 0, 0, 0, 0, 1, 3, 0, 0, mk(0,1,0,0,0,0), mk(0,1,0,0,0,0));
        step(0, 1, 3, 0, 1, 0, 0, 0, 0, 0, mk(0,1,1,0,1,0), mk(1,0,0,0,1,0));
        step(0, 1, 3, 0, 1, 0, 0, 0, 0, 0, mk(0,1,2,0,1,0), mk(1,0,0,0,1,1));
        step(0, 1, 3, 0, 1, 0, 0, 0, 0, 0, mk(0,1,3,0,1,0), mk(1,0,0,0,1,2));
        step(0, 1, 3, 0, 1, 0, 0, 0, 0, 0, mk(0,1,0,0,0,0), mk(0,1,0,0,0,3));
        // 6..9: load r2, load-use on ry
        step(0, 1, 0, 0, 0, 0, 1, 2, 1, 0, mk(0,1,0,0,0,0), mk(0,1,0,0,0,3));
        step(0, 1, 0, 2, 0, 1, 0, 0, 0, 0, mk(1,0,0,0,1,0), mk(1,0,0,0,1,3));
        step(0, 1, 0, 2, 0, 1, 0, 0, 0, 0, mk(0,1,0,2,1,1), mk(1,0,0,0,1,4));
        step(0, 1, 0, 2, 0, 1, 0, 0, 0, 0, mk(0,1,0,3,1,1), mk(1,0,0,0,1,5));
        // 10..14: r5 in slots 1 and 3, r6 in slot 2; youngest match wins, rx/ry independent
        step(0, 1, 0, 0, 0, 0, 1, 5, 0, 0, mk(0,1,0,0,0,1), mk(0,1,0,0,0,6));
        step(0, 1, 0, 0, 0, 0, 1, 6, 0, 0, mk(0,1,0,0,1,1), mk(0,1,0,0,1,6));
        step(0, 1, 0, 0, 0, 0, 1, 5, 0, 0, mk(0,1,0,0,2,1), mk(0,1,0,0,2,6));
        step(0, 1, 5, 6, 1, 1, 0, 0, 0, 0, mk(0,1,1,2,3,1), mk(1,0,0,0,3,6));
        step(0, 1, 5, 6, 1, 1, 0, 0, 0, 0, mk(0,1,2,3,2,1), mk(1,0,0,0,2,7));
        // 15..16: flush of a writer; slot1 gets a bubble, r5 retires, count drops to 0
        step(0, 1, 5, 0, 1, 0, 1, 7, 0, 1, mk(0,0,3,0,1,1), mk(1,0,0,0,1,8));
        step(0, 1, 0, 0, 0, 0, 1, 1, 0, 0, mk(0,1,0,0,0,1), mk(0,1,0,0,0,8));
        // 17..19: flush during a load-use stall does not count; d_valid=0 masks everything
        step(0, 1, 0, 0, 0, 0, 1, 4, 1, 0, mk(0,1,0,0,1,1), mk(0,1,0,0,1,8));
        step(0, 1, 0, 4, 0, 1, 1, 2, 0, 1, mk(1,0,0,0,2,1), mk(1,0,0,0,2,8));
        step(0, 0, 1, 4, 1, 1, 0, 0, 0, 0, mk(0,0,0,0,2,1), mk(0,0,0,0,2,8));
        // 20..23: reset asserted mid load-use stall takes effect before the next edge
        step(0, 1, 0, 0, 0, 0, 1, 6, 1, 0, mk(0,1,0,0,1,1), mk(0,1,0,0,1,8));
        step(0, 1, 6, 0, 1, 0, 0, 0, 0, 0, mk(1,0,0,0,1,1), mk(1,0,0,0,1,8));
        step(1, 1, 6, 0, 1, 0, 0, 0, 0, 0, mk(0,1,0,0,0,0), mk(0,1,0,0,0,0));
        step(0, 1, 6, 6, 1, 1, 0, 0, 0, 0, mk(0,1,0,0,0,0), mk(0,1,0,0,0,0));

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        if (exp_q.size() > 0) begin
            checks++;
            $display("FAIL drain: got %0d entries left, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
